// File: rtl/app_csr_pkg.sv
// app_csr_pkg: shared CSR header types for the application CSR block.
package app_csr_pkg;
    localparam int NUM_APP_CSRS = 16;

    typedef logic [63:0] t_cpu_rd_csrs;
    typedef logic [39:0] t_csr_mgr_counter;

    typedef struct packed {
        logic        en;
        logic [63:0] data;
    } t_cpu_wr_csrs;
endpackage

// File: rtl/csr_mmio_pkg.sv
// csr_mmio_pkg: MMIO address map and read-pipeline request type.
package csr_mmio_pkg;
    localparam logic [15:0] MMIO_DFH           = 16'h0000;
    localparam logic [15:0] MMIO_AFU_ID_L      = 16'h0002;
    localparam logic [15:0] MMIO_AFU_ID_H      = 16'h0004;
    localparam logic [15:0] MMIO_RSVD0         = 16'h0006;
    localparam logic [15:0] MMIO_RSVD1         = 16'h0008;
    localparam logic [15:0] MMIO_COUNTER       = 16'h0010;
    localparam logic [15:0] MMIO_CSR_BASE_DFLT = 16'h0020;

    typedef struct packed {
        logic [15:0] addr;
        logic [8:0]  tid;
    } t_mmio_rd_req;
endpackage

// File: rtl/app_csrs.sv
// app_csrs: CSR exchange between the MMIO bridge (csr) and the application (app).
interface app_csrs
    import app_csr_pkg::*;
    ;
    logic [127:0] afu_id;
    t_cpu_rd_csrs cpu_rd_csrs [NUM_APP_CSRS];
    t_cpu_wr_csrs cpu_wr_csrs [NUM_APP_CSRS];

    modport csr (input afu_id, input cpu_rd_csrs, output cpu_wr_csrs);
    modport app (output afu_id, output cpu_rd_csrs, input cpu_wr_csrs);
endinterface

// File: rtl/csr_mmio_bridge_if.sv
// csr_mmio_bridge_if: CCI-P MMIO write/read request channels and read response.
interface csr_mmio_bridge_if;
    logic        mmio_wr_valid;
    logic [15:0] mmio_wr_addr;
    logic        mmio_wr_len64;
    logic [63:0] mmio_wr_data;
    logic        mmio_rd_valid;
    logic [15:0] mmio_rd_addr;
    logic [8:0]  mmio_rd_tid;
    logic        rsp_valid;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;

    modport master (
        output mmio_wr_valid, mmio_wr_addr, mmio_wr_len64, mmio_wr_data,
        output mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
        input  rsp_valid, rsp_tid, rsp_data
    );
    modport slave (
        input  mmio_wr_valid, mmio_wr_addr, mmio_wr_len64, mmio_wr_data,
        input  mmio_rd_valid, mmio_rd_addr, mmio_rd_tid,
        output rsp_valid, rsp_tid, rsp_data
    );
endinterface

// File: rtl/csr_mmio_rd_pipe.sv
// csr_mmio_rd_pipe: two-stage MMIO read pipeline; stage 1 captures the request,
// stage 2 registers the decoded read data and the response.
module csr_mmio_rd_pipe
    import app_csr_pkg::*, csr_mmio_pkg::*;
#(
    parameter logic [63:0] DFH_VALUE     = 64'h1000_0100_0000_0000,
    parameter logic [15:0] CSR_BASE_WORD = MMIO_CSR_BASE_DFLT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_valid,
    input  logic [15:0]      rd_addr,
    input  logic [8:0]       rd_tid,
    input  t_csr_mgr_counter counter,
    input  logic [127:0]     afu_id,
    input  t_cpu_rd_csrs     rd_csrs [NUM_APP_CSRS],
    output logic             rsp_valid,
    output logic [8:0]       rsp_tid,
    output logic [63:0]      rsp_data
);
    localparam int IW = $clog2(NUM_APP_CSRS);

    t_mmio_rd_req s1_req;
    logic         s1_valid;
    logic [15:0]  off;
    logic         csr_hit;
    logic [63:0]  mux_data;

    // App CSRs sit on even offsets from the base; odd words never decode.
    assign off     = s1_req.addr - CSR_BASE_WORD;
    assign csr_hit = !off[0] && (off[15:1] < 15'(NUM_APP_CSRS));

    always_comb begin
        mux_data = (s1_req.addr == MMIO_DFH)      ? DFH_VALUE :
                   (s1_req.addr == MMIO_AFU_ID_L) ? afu_id[63:0] :
                   (s1_req.addr == MMIO_AFU_ID_H) ? afu_id[127:64] :
                   (s1_req.addr == MMIO_RSVD0 || s1_req.addr == MMIO_RSVD1) ? 64'd0 :
                   (s1_req.addr == MMIO_COUNTER)  ? {24'd0, counter} :
                   csr_hit ? rd_csrs[off[IW:1]] : 64'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_req    <= '0;
            rsp_valid <= 1'b0;
            rsp_tid   <= '0;
            rsp_data  <= '0;
        end else begin
            s1_valid  <= rd_valid;
            s1_req    <= '{addr: rd_addr, tid: rd_tid};
            rsp_valid <= s1_valid;
            rsp_tid   <= s1_req.tid;
            rsp_data  <= mux_data;
        end
    end
endmodule

// File: rtl/csr_mmio_bridge.sv
// csr_mmio_bridge: decodes MMIO writes into one-cycle app CSR write pulses and
// serves MMIO reads from DFH, AFU ID, the cycle counter and app read CSRs.
module csr_mmio_bridge
    import app_csr_pkg::*, csr_mmio_pkg::*;
#(
    parameter logic [63:0] DFH_VALUE     = 64'h1000_0100_0000_0000,
    parameter logic [15:0] CSR_BASE_WORD = MMIO_CSR_BASE_DFLT
) (
    input  logic clk,
    input  logic reset,
    csr_mmio_bridge_if.slave mmio,
    app_csrs.csr csrs
);
    t_csr_mgr_counter counter;
    logic [15:0]      wr_off;
    logic             wr_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) counter <= '0;
        else counter <= counter + 1'b1;
    end

    // Only full 64-bit writes to an app CSR slot take effect.
    assign wr_off = mmio.mmio_wr_addr - CSR_BASE_WORD;
    assign wr_hit = mmio.mmio_wr_valid && mmio.mmio_wr_len64 && !wr_off[0] &&
                    (wr_off[15:1] < 15'(NUM_APP_CSRS));

    for (genvar i = 0; i < NUM_APP_CSRS; i++) begin : g_wr
        logic sel;
        assign sel = wr_hit && (wr_off[15:1] == 15'(i));
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                csrs.cpu_wr_csrs[i].en   <= 1'b0;
                csrs.cpu_wr_csrs[i].data <= '0;
            end else begin
                csrs.cpu_wr_csrs[i].en <= sel;
                if (sel) csrs.cpu_wr_csrs[i].data <= mmio.mmio_wr_data;
            end
        end
    end

    csr_mmio_rd_pipe #(
        .DFH_VALUE     (DFH_VALUE),
        .CSR_BASE_WORD (CSR_BASE_WORD)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .rd_valid  (mmio.mmio_rd_valid),
        .rd_addr   (mmio.mmio_rd_addr),
        .rd_tid    (mmio.mmio_rd_tid),
        .counter   (counter),
        .afu_id    (csrs.afu_id),
        .rd_csrs   (csrs.cpu_rd_csrs),
        .rsp_valid (mmio.rsp_valid),
        .rsp_tid   (mmio.rsp_tid),
        .rsp_data  (mmio.rsp_data)
    );
endmodule

// File: tb/tb_csr_mmio_bridge.sv
// tb_csr_mmio_bridge: directed stimulus with queued expectations; independent
// monitors compare read responses and write pulses as the DUT presents them.
module tb_csr_mmio_bridge;
    timeunit 1ns;
    timeprecision 100ps;

    localparam logic [63:0]  DFH  = 64'h1000_0100_0000_0000;
    localparam logic [127:0] AFU  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [39:0]  WRAP = 40'hFF_FFFF_FFFE;

    typedef struct { logic [8:0] tid; logic [63:0] data; int due; } rd_exp_t;
    typedef struct { int idx; logic [63:0] data; int due; } wr_exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    rd_exp_t rd_q[$];
    wr_exp_t wr_q[$];

    csr_mmio_bridge_if mmio();
    app_csrs csrs();

    csr_mmio_bridge dut (.clk(clk), .reset(reset), .mmio(mmio), .csrs(csrs));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Read response monitor
    always @(posedge clk) begin
        #1;
        if (mmio.rsp_valid) begin
            if (rd_q.size() == 0) chk("unexpected_rsp_valid", 64'd1, 64'd0);
            else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.due));
                chk("rsp_tid", 64'(mmio.rsp_tid), 64'(e.tid));
                chk("rsp_data", mmio.rsp_data, e.data);
            end
        end
    end

    // Write pulse monitor
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 16; i++) begin
            if (csrs.cpu_wr_csrs[i].en) begin
                if (wr_q.size() == 0) chk("unexpected_wr_en", 64'(i), 64'hFFFF);
                else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(e.due));
                    chk("wr_idx", 64'(i), 64'(e.idx));
                    chk("wr_data", csrs.cpu_wr_csrs[i].data, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        mmio.mmio_wr_valid = 1'b0;
        mmio.mmio_rd_valid = 1'b0;
    endtask

    task automatic rd(input logic [15:0] addr, input logic [8:0] tid,
                      input logic [63:0] exp, input bit push);
        mmio.mmio_rd_valid = 1'b1;
        mmio.mmio_rd_addr  = addr;
        mmio.mmio_rd_tid   = tid;
        if (push) rd_q.push_back('{tid: tid, data: exp, due: cyc + 2});
    endtask

    task automatic wr(input logic [15:0] addr, input logic len64, input logic [63:0] data,
                      input int idx);
        mmio.mmio_wr_valid = 1'b1;
        mmio.mmio_wr_addr  = addr;
        mmio.mmio_wr_len64 = len64;
        mmio.mmio_wr_data  = data;
        if (idx >= 0) wr_q.push_back('{idx: idx, data: data, due: cyc + 1});
    endtask

    task automatic chk_quiet(input string name);
        logic any_en;
        logic [63:0] any_data;
        any_en = 1'b0;
        any_data = '0;
        for (int i = 0; i < 16; i++) begin
            any_en |= csrs.cpu_wr_csrs[i].en;
            any_data |= csrs.cpu_wr_csrs[i].data;
        end
        chk({name, "_rsp_valid"}, 64'(mmio.rsp_valid), 64'd0);
        chk({name, "_rsp_tid"}, 64'(mmio.rsp_tid), 64'd0);
        chk({name, "_rsp_data"}, mmio.rsp_data, 64'd0);
        chk({name, "_wr_en"}, 64'(any_en), 64'd0);
        chk({name, "_wr_data"}, any_data, 64'd0);
    endtask

    initial begin
        mmio.mmio_wr_valid = 1'b0;
        mmio.mmio_wr_addr  = '0;
        mmio.mmio_wr_len64 = 1'b0;
        mmio.mmio_wr_data  = '0;
        mmio.mmio_rd_valid = 1'b0;
        mmio.mmio_rd_addr  = '0;
        mmio.mmio_rd_tid   = '0;
        csrs.afu_id = AFU;
        for (int i = 0; i < 16; i++) csrs.cpu_rd_csrs[i] = 64'h1000 + 64'(i);
        csrs.cpu_rd_csrs[15] = 64'h55AA;
        tick();
        tick();
        chk_quiet("reset");
        tick();
        reset = 1'b0;
        wr(16'h0026, 1'b1, 64'hDEAD_BEEF_0000_0001, 3);
        tick();
        wr(16'h0020, 1'b0, 64'h1111, -1);
        tick();
        wr(16'h0000, 1'b1, 64'h2222, -1);
        tick();
        rd(16'h0000, 9'd1, DFH, 1'b1);
        tick();
        rd(16'h0002, 9'd2, AFU[63:0], 1'b1);
        tick();
        rd(16'h0004, 9'd3, AFU[127:64], 1'b1);
        tick();
        rd(16'h0021, 9'd4, 64'd0, 1'b1);
        tick();
        rd(16'h0020, 9'd10, 64'h1000, 1'b1);
        wr(16'h0020, 1'b1, 64'hA0, 0);
        tick();
        rd(16'h0006, 9'd11, 64'd0, 1'b1);
        wr(16'h0022, 1'b1, 64'hA1, 1);
        tick();
        rd(16'h0011, 9'd12, 64'd0, 1'b1);
        wr(16'h0040, 1'b1, 64'hA2, -1);
        tick();
        rd(16'h0040, 9'd13, 64'd0, 1'b1);
        tick();
        chk("wr_data_hold", csrs.cpu_wr_csrs[3].data, 64'hDEAD_BEEF_0000_0001);
        force dut.counter = WRAP;
        rd(16'h0010, 9'd5, 64'h00FF_FFFF_FFFF, 1'b1);
        #1 release dut.counter;
        tick();
        tick();
        rd(16'h0010, 9'd6, 64'd1, 1'b1);
        tick();
        rd(16'h003E, 9'd9, 64'h55AA, 1'b1);
        wr(16'h003E, 1'b1, 64'h1234, 15);
        tick();
        tick();
        tick();
        rd(16'h0002, 9'd7, 64'd0, 1'b0);
        wr(16'h0024, 1'b1, 64'hBAD, -1);
        @(posedge clk);
        #0.5 reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_quiet("midreset");
        end
        tick();
        reset = 1'b0;
        rd(16'h0010, 9'd8, 64'd1, 1'b1);
        for (int k = 0; k < 6; k++) tick();
        chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/csr_mmio_bridge.md
# csr_mmio_bridge

Host-facing MMIO front end for the application CSR interface. It decodes CCI-P MMIO write and read requests and drives the `csr` modport of `app_csrs`:
- Writes become one-cycle `cpu_wr_csrs[i].en` pulses.
- Reads are answered from the DFH, the AFU ID, a free-running cycle counter, or `cpu_rd_csrs[i]`.

It sits between the CCI-P shim's MMIO channels and the application module.

## Interface
- `DFH_VALUE`, default `64'h1000_0100_0000_0000`: returned on DFH reads.
- `CSR_BASE_WORD`, default `16'h0020`: 32-bit-word address of app CSR 0. App CSR i is at `CSR_BASE_WORD + 2*i`.
- `clk` in, 1: sole clock.
- `reset` in, 1: asynchronous, active-high.
- `mmio_wr_valid` in, 1: MMIO write request.
- `mmio_wr_addr` in, 16: 32-bit-word address.
- `mmio_wr_len64` in, 1: 1 means 64-bit write; 0 means 32-bit write.
- `mmio_wr_data` in, 64: write data.
- `mmio_rd_valid` in, 1: MMIO read request.
- `mmio_rd_addr` in, 16: 32-bit-word address.
- `mmio_rd_tid` in, 9: read transaction ID.
- `rsp_valid` out, 1: read response strobe.
- `rsp_tid` out, 9: echoed transaction ID.
- `rsp_data` out, 64: read data.
- `csrs` modport `app_csrs.csr`:
  - inputs: `afu_id`, `cpu_rd_csrs[0:NUM_APP_CSRS-1]`
  - outputs: `cpu_wr_csrs[0:NUM_APP_CSRS-1]`

## Operation
Address map (word addresses; only 64-bit-aligned, i.e. even, addresses decode):
- `0x0000`: DFH (read-only).
- `0x0002`: `afu_id[63:0]`.
- `0x0004`: `afu_id[127:64]`.
- `0x0006`, `0x0008`: DFH reserved, read 0.
- `0x0010`: cycle counter, zero-extended from 40 bits.
- `CSR_BASE_WORD + 2*i`, i < `NUM_APP_CSRS`: app CSR i.
- Any other address, including odd addresses: reads return 0, writes are ignored.

Write path:
- Only a 64-bit write to an app CSR address takes effect.
- Effect: `cpu_wr_csrs[i].en` = 1 for exactly one cycle, with `.data` = `mmio_wr_data`.
- 32-bit writes and writes to read-only or unmapped addresses are dropped silently.
- `.data` holds its last written value while `en` = 0.

Read path:
- Two-stage pipeline:
  - stage 1 registers valid, address and tid;
  - stage 2 registers the mux output and the response.
- One request per cycle is accepted. There is no backpressure, and responses come out in request order.
- Read CSRs and write CSRs are independent storage. A write does not change what a read of the same index returns.

Cycle counter:
- `t_csr_mgr_counter` (40 bits), incremented every cycle out of reset.
- Wraps from 2^40-1 to 0.

## Timing
- Write presented at cycle T: `en` is high during T+1 only. Back-to-back writes give back-to-back pulses, possibly on different indices.
- Read presented at cycle T: `rsp_valid`, `rsp_tid` and `rsp_data` are valid during T+2.
- Counter read at T returns the counter value registered at T+1.
- Read and write at the same cycle and same index: the read returns `cpu_rd_csrs[i]` sampled at T+1, and the write pulses at T+1.
- Reset values:
  - `rsp_valid` = 0, `rsp_tid` = 0, `rsp_data` = 0.
  - All `cpu_wr_csrs[i].en` = 0 and `.data` = 0.
  - Counter = 0.
- Reset asserted mid-operation: in-flight reads are discarded (no response is ever produced), and a pending write pulse is cancelled. Outputs take their reset values asynchronously.
- The first request after reset deassertion is accepted on the first rising edge with `reset` low.

## Structure
- Shared package `csr_mmio_pkg` holds:
  - the address-map localparams (DFH, AFU ID low/high, reserved, counter, default CSR base);
  - a packed struct `t_mmio_rd_req` {addr, tid} used by the pipeline registers.
- `NUM_APP_CSRS`, `t_cpu_rd_csrs`, `t_cpu_wr_csrs` and `t_csr_mgr_counter` come from the existing CSR header and are not redefined.
- One sub-module, `csr_mmio_rd_pipe`: the two-stage read pipeline with decode mux, taking the counter value as an input. The write decode and the counter stay in the top level.

## Test plan
- After reset, 64-bit write to word `0x0026` (CSR 3) with data `0xDEADBEEF_00000001` -> `cpu_wr_csrs[3].en` high for exactly one cycle at T+1 with that data; all other `en` stay 0.
- 32-bit write to `0x0020`, then 64-bit write to `0x0000` -> no `en` pulse on any index.
- Reads on consecutive cycles of `0x0000`, `0x0002`, `0x0004`, `0x0021` with tids 1, 2, 3, 4 -> responses at T+2..T+5 in order:
  - `DFH_VALUE`, tid 1;
  - `afu_id[63:0]`, tid 2;
  - `afu_id[127:64]`, tid 3;
  - 0, tid 4.
- Counter forced near wrap: read `0x0010` at the cycles when the counter is 2^40-2 and then 0 -> returned values are 2^40-1 and 1.
- Set `cpu_rd_csrs[15]` = `0x55AA`. Read `0x003E` and write `0x003E` with `0x1234` in the same cycle -> read returns `0x55AA`, and `en[15]` pulses with `0x1234`.
- Assert `reset` one cycle after a read request and a write request -> no `rsp_valid` and no `en` pulse, outputs are 0 while reset is high, and the counter restarts from 0.
